// File: rtl/nibble_serial_arith_ctrl.sv
// nibble_serial_arith_ctrl: wide add/sub run one nibble per cycle through a 4-bit slice.
// Optional `ARITH_ZERO_FLAG_EN adds a registered zero-result flag port.
module nibble_serial_arith_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow,
`ifdef ARITH_ZERO_FLAG_EN
  output logic                 zero,
`endif
  output logic                 busy
);
  localparam int W = 4*NIBBLES;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic sel_q, sel_d, carry_q, carry_d, carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic zero_q, zero_d;
  logic [3:0] cnt_q, cnt_d, a_n, b_n;
  logic [4:0] sum;
  logic [5:0] sh;
  logic last;
  always_comb begin
    sh = {cnt_q, 2'b00};
    a_n = 4'(a_q >> sh);
    b_n = 4'(b_q >> sh) ^ {4{sel_q}};
    sum = {1'b0, a_n} + {1'b0, b_n} + 5'(carry_q);
    last = cnt_q == 4'(NIBBLES-1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    result_d = result_q;
    carry_out_d = carry_out_q;
    overflow_d = overflow_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        sel_d = sel;
        cnt_d = '0;
        carry_d = sel;
        state_d = RUN;
      end
      RUN: begin
        result_d = (result_q & ~(W'(4'hF) << sh)) | (W'(sum[3:0]) << sh);
        carry_d = sum[4];
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          // borrow is the inverted final carry of a + ~b + 1
          carry_out_d = sum[4] ^ sel_q;
          overflow_d = (a_n[3] == b_n[3]) & (sum[3] != a_n[3]);
          zero_d = result_d == '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sel_q <= 1'b0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      result_q <= '0;
      carry_out_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      result_q <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q <= overflow_d;
      zero_q <= zero_d;
    end
  end
  assign in_ready = (state_q == IDLE) & rst_n;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign result = result_q;
  assign carry_out = carry_out_q;
  assign overflow = overflow_q;
`ifdef ARITH_ZERO_FLAG_EN
  assign zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif
endmodule
